ps2_digit_display: RTL and testbench
====================================

// Module: ps2_digit_display
// PURPOSE
//  Consumes the decoded key stream from the PS/2 receiver (digit / strobe pair) and holds the
//  last NUM_DIGITS keys in a shift buffer. Drives a time-multiplexed, common-anode 7-segment
//  display with that buffer. Sits directly downstream of the PS/2 decoder, on the same clock.
// PARAMETERS
//  NUM_DIGITS   4     number of display positions / buffered digits (>=2)
//  REFRESH_DIV  1000  clk_i cycles each digit stays lit (>=2); benches use 4
// PORTS
//  clk_i       in   1             system clock, all logic on rising edge
//  rst_i       in   1             asynchronous, active-high reset
//  digit_i     in   4             key code from PS/2 decoder (0-9 digit, 4'hB backspace)
//  new_data_i  in   1             key-valid from PS/2 decoder; rising edge = one key event
//  seg_o       out  7             segments {g,f,e,d,c,b,a}, active-low, registered
//  an_o        out  NUM_DIGITS    digit enables, active-low one-hot, registered
//  value_o     out  4*NUM_DIGITS  buffer contents, digit 0 (newest) in [3:0]
// BEHAVIOUR
//  Reset (async, immediate, also mid-scan/mid-entry): buffer=0, fill count=0, prescaler=0,
//   scan idx=0, edge reg=0, value_o=0, an_o=all 1s (dark), seg_o=7'h7F (blank).
//  Key event: evt = new_data_i & ~new_data_q; a level held N cycles is exactly one event.
//   digit_i 0-9: buffer <= {buffer[4*NUM_DIGITS-5:0], digit_i}; oldest digit dropped;
//    fill count +1, saturating at NUM_DIGITS.
//   digit_i 4'hB: buffer <= {4'h0, buffer[4*NUM_DIGITS-1:4]}; fill count -1, saturating at 0.
//   Any other code: ignored, no state change.
//  value_o reflects the event on the clock edge that detects it (1-cycle latency from strobe).
//  Scan: prescaler counts 0..REFRESH_DIV-1 and wraps. On the cycle where prescaler == REFRESH_DIV-1,
//   idx advances; NUM_DIGITS-1 wraps to 0.
//  Output registers: each cycle an_o <= ~(1<<idx) and seg_o <= decode(buffer[idx]).
//   Outputs lag idx/buffer by one cycle; the first lit digit appears 1 cycle after reset release.
//  Simultaneous key event and idx advance: both take effect on the same edge; seg_o picks up
//   the new buffer on the next edge.
//  Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex);
//   codes >9 never reach the buffer.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: position p is blanked (seg_o=7'h7F, an_o still scanned) when
//   p >= max(fill count,1); digit 0 is always shown, so the empty display reads "0".
//  LEADING_ZERO_BLANK_EN undefined: every position shows its decoded digit; fill count is
//   still maintained but does not affect outputs.
// STRUCTURE
//  Shared header ps2_display_defs.vh holds KEY_BACKSPACE (4'hB), SEG_BLANK (7'h7F), and the
//   SEG_0..SEG_9 constants.
//  Sub-module seg7_decoder: combinational 4-bit -> 7-bit active-low lookup, one instance on the
//   muxed digit.
//  Top level holds the edge detector, shift buffer, fill counter, prescaler, scan idx, and
//   output registers.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4)
//  1 Reset pulse -> an_o=4'b1111, seg_o=7'h7F, value_o=16'h0000; assert rst_i mid-scan ->
//    same values with no clock edge required.
//  2 Strobes for 1,2,3 (1-cycle pulses) -> value_o=16'h0123; then 4'hB -> 16'h0012;
//    then 4'hC -> unchanged.
//  3 Keys 1,2,3,4,5 -> value_o=16'h2345 (digit 1 dropped); new_data_i held 3 cycles with 6 ->
//    one shift only, giving 16'h3456.
//  4 Free run with buffer 16'h0123 -> an_o cycles 1110,1101,1011,0111, 4 clocks each, with
//    seg_o = 7'h30,7'h24,7'h79,7'h40 in step.
//  5 Key 9 arrives on the same edge that idx wraps to 0 -> next edge shows an_o=1110,
//    seg_o=7'h10.
//  6 With LEADING_ZERO_BLANK_EN, after reset then key 7 -> position 0 shows 7'h78, positions
//    1-3 show 7'h7F; without the macro, positions 1-3 show 7'h40.

Source files
------------

// File: rtl/ps2_digit_display_pkg.sv
// ---------------------------------------------------------------------------
// ps2_digit_display_pkg
//   Shared constants for the PS/2 digit display slice: the backspace key code
//   and the active-low 7-segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit).
//   Imported by seg7_decoder and ps2_digit_display.
// ---------------------------------------------------------------------------
package ps2_digit_display_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Classifies a decoder key code as a printable digit.
  function automatic logic is_digit_key(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/ps2_digit_display_seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
//   Combinational BCD -> active-low 7-segment lookup.
//   Ports:
//     digit_i  in  4  digit value 0-9
//     seg_o    out 7  {g,f,e,d,c,b,a}, active-low; blank for codes above 9
// ---------------------------------------------------------------------------
module seg7_decoder
  import ps2_digit_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ps2_digit_display.sv
// ---------------------------------------------------------------------------
// ps2_digit_display
//   Buffers the last NUM_DIGITS keys from the PS/2 decoder (newest in digit 0)
//   and scans them onto a time-multiplexed common-anode 7-segment display.
//   Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks positions at or
//   beyond the number of entered digits (digit 0 always shown).
//   Ports:
//     clk_i       in   1             system clock
//     rst_i       in   1             asynchronous active-high reset
//     digit_i     in   4             key code (0-9 digit, 4'hB backspace)
//     new_data_i  in   1             key strobe; rising edge = one key event
//     seg_o       out  7             active-low segments, registered
//     an_o        out  NUM_DIGITS    active-low one-hot digit enable, registered
//     value_o     out  4*NUM_DIGITS  buffer contents, newest digit in [3:0]
// ---------------------------------------------------------------------------
module ps2_digit_display
  import ps2_digit_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
)
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [3:0]              digit_i,
  input  logic                    new_data_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [4*NUM_DIGITS-1:0] value_o
);

  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                  newData_q;
  logic [BUF_W-1:0]      digitBuf_q, digitBuf_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       keyEvt;
  logic       scanTick;
  logic [3:0] muxDigit;
  logic [6:0] decodedSeg;
  logic       blankPos;

  // A held strobe level counts once: only the low-to-high transition is an event.
  assign keyEvt   = new_data_i & ~newData_q;
  assign scanTick = (presc_q == PRE_W'(REFRESH_DIV - 1));

  // Key handling: digits shift in at position 0, backspace shifts everything
  // back toward position 0 and zero-fills the oldest slot; other codes ignored.
  always_comb begin
    digitBuf_d = digitBuf_q;
    fill_d     = fill_q;
    if (keyEvt) begin
      if (is_digit_key(digit_i)) begin
        digitBuf_d = {digitBuf_q[BUF_W-5:0], digit_i};
        if (fill_q != CNT_W'(NUM_DIGITS)) begin
          fill_d = fill_q + 1'b1;
        end
      end else if (digit_i == KEY_BACKSPACE) begin
        digitBuf_d = {4'h0, digitBuf_q[BUF_W-1:4]};
        if (fill_q != '0) begin
          fill_d = fill_q - 1'b1;
        end
      end
    end
  end

  // Prescaler and scan index; the index steps on the prescaler's last count.
  always_comb begin
    presc_d = scanTick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (scanTick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the digit under the current scan index and build its anode pattern.
  always_comb begin
    muxDigit = 4'h0;
    an_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        muxDigit = digitBuf_q[4*i +: 4];
        an_d[i]  = 1'b0;
      end
    end
  end

  seg7_decoder u_seg7_decoder (
    .digit_i (muxDigit),
    .seg_o   (decodedSeg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Position 0 is always lit; higher positions light only once that many
  // digits have been entered, which is p >= max(fill,1) folded into one test.
  assign blankPos = (idx_q != '0) && (32'(idx_q) >= 32'(fill_q));
`else
  // Fill count is still tracked so enabling blanking needs no datapath change.
  logic unused_fill;
  assign blankPos    = 1'b0;
  assign unused_fill = ^fill_q;
`endif

  assign seg_d = blankPos ? SEG_BLANK : decodedSeg;

  // All state, including the registered display outputs (one cycle behind idx/buffer).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      newData_q  <= 1'b0;
      digitBuf_q <= '0;
      fill_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      newData_q  <= new_data_i;
      digitBuf_q <= digitBuf_d;
      fill_q     <= fill_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign value_o = digitBuf_q;

endmodule

// File: tb/tb_ps2_digit_display.sv
// ---------------------------------------------------------------------------
// tb_ps2_digit_display
//   Self-checking bench for ps2_digit_display (NUM_DIGITS=4, REFRESH_DIV=4).
//   A behavioural model keeps the digit list as an array and derives the scan
//   position from the number of clocks since reset.
// ---------------------------------------------------------------------------
module tb_ps2_digit_display;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk_i;
  logic         rst_i;
  logic [3:0]   digit_i;
  logic         new_data_i;
  logic [6:0]   seg_o;
  logic [N-1:0] an_o;
  logic [4*N-1:0] value_o;

  ps2_digit_display #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .digit_i    (digit_i),
    .new_data_i (new_data_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .value_o    (value_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errorCount = 0;
  int checkCount = 0;

  // Reference state: digit list (index 0 newest), entered count, edges since reset.
  int         mDigits[N];
  int         mFill;
  int         tEdges;
  logic       mPrevNd;
  logic [6:0] segTab[10];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [4*N-1:0] modelValue();
    logic [4*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(mDigits[i]);
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) mDigits[i] = 0;
    mFill   = 0;
    tEdges  = 0;
    mPrevNd = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and check all outputs.
  task automatic applyStimulus(input logic nd, input logic [3:0] dg);
    int         pos;
    int         shownDigit;
    int         fillBefore;
    logic [N-1:0] anExp;
    logic [6:0] segExp;
    new_data_i = nd;
    digit_i    = dg;
    @(posedge clk_i);
    pos        = (tEdges / DIV) % N;
    shownDigit = mDigits[pos];
    fillBefore = mFill;
    tEdges++;
    if (nd && !mPrevNd) begin
      if (dg <= 4'd9) begin
        for (int i = N - 1; i > 0; i--) mDigits[i] = mDigits[i-1];
        mDigits[0] = int'(dg);
        if (mFill < N) mFill++;
      end else if (dg == 4'hB) begin
        for (int i = 0; i < N - 1; i++) mDigits[i] = mDigits[i+1];
        mDigits[N-1] = 0;
        if (mFill > 0) mFill--;
      end
    end
    mPrevNd = nd;
    anExp      = '1;
    anExp[pos] = 1'b0;
    segExp     = segTab[shownDigit];
`ifdef LEADING_ZERO_BLANK_EN
    if (pos >= ((fillBefore < 1) ? 1 : fillBefore)) segExp = 7'h7F;
`else
    if (fillBefore < 0) segExp = 7'h7F;
`endif
    @(negedge clk_i);
    checkOutput("value", 32'(value_o), 32'(modelValue()));
    checkOutput("an", 32'(an_o), 32'(anExp));
    checkOutput("seg", 32'(seg_o), 32'(segExp));
  endtask

  task automatic pressKey(input logic [3:0] dg);
    applyStimulus(1'b1, dg);
    applyStimulus(1'b0, dg);
  endtask

  // Assert reset between edges and check outputs respond with no clock edge.
  task automatic pulseReset();
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_an", 32'(an_o), 32'hF);
    checkOutput("rst_seg", 32'(seg_o), 32'h7F);
    checkOutput("rst_value", 32'(value_o), 32'h0);
    new_data_i = 1'b0;
    digit_i    = 4'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelReset();
  endtask

  initial begin
    segTab[0] = 7'h40; segTab[1] = 7'h79; segTab[2] = 7'h24; segTab[3] = 7'h30;
    segTab[4] = 7'h19; segTab[5] = 7'h12; segTab[6] = 7'h02; segTab[7] = 7'h78;
    segTab[8] = 7'h00; segTab[9] = 7'h10;
    rst_i      = 1'b1;
    new_data_i = 1'b0;
    digit_i    = 4'h0;
    modelReset();
    @(negedge clk_i);
    pulseReset();

    // Basic entry, backspace, ignored code.
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'd3);
    checkOutput("v0123", 32'(value_o), 32'h0123);
    pressKey(4'hB);
    checkOutput("v0012", 32'(value_o), 32'h0012);
    pressKey(4'hC);
    checkOutput("vIgnored", 32'(value_o), 32'h0012);

    // Overflow drops the oldest digit; a held strobe is a single event.
    pressKey(4'd3);
    pressKey(4'd4);
    pressKey(4'd5);
    checkOutput("v2345", 32'(value_o), 32'h2345);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b0, 4'd6);
    checkOutput("v3456", 32'(value_o), 32'h3456);

    // Mid-scan reset, then free-run scan over 0123.
    pulseReset();
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'd3);
    for (int i = 0; i < 2 * N * DIV; i++) applyStimulus(1'b0, 4'd0);

    // Key 9 on the very edge where the scan index wraps back to 0.
    while (((tEdges + 1) % (N * DIV)) != 0) applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b1, 4'd9);
    applyStimulus(1'b0, 4'd0);
    checkOutput("wrap_an", 32'(an_o), 32'hE);
    checkOutput("wrap_seg", 32'(seg_o), 32'h10);

    // Single digit after reset exercises the blanking policy.
    pulseReset();
    pressKey(4'd7);
    for (int i = 0; i < N * DIV + 2; i++) applyStimulus(1'b0, 4'd0);

    // Randomized key stream with occasional held strobes and stray codes.
    for (int i = 0; i < 500; i++) begin
      logic       nd;
      logic [3:0] dg;
      int         r;
      r  = int'($urandom_range(0, 9));
      nd = ($urandom_range(0, 2) == 0);
      if (r < 7)       dg = 4'($urandom_range(0, 9));
      else if (r < 9)  dg = 4'hB;
      else             dg = 4'($urandom_range(10, 15));
      applyStimulus(nd, dg);
      if (i == 250) pulseReset();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Safety bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
